// File: rtl/debounce_pkg.sv
// Shared types and configuration checks for the debounce/synchronizer block.
package debounce_pkg;

    // Two idle states hold the settled level; the CHK states qualify a candidate edge.
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE      = 4;
    localparam int DEF_CNT_W       = 4;

    // The counter must hold STABLE-1 without wrapping, and at least one sample is needed.
    function automatic bit cfg_ok(input int sync_stages, input int stable, input int cnt_w);
        return (sync_stages >= 2) && (stable >= 1) && ((2 ** cnt_w) > stable);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop shift chain bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s
);

    logic [SYNC_STAGES-1:0] sr;

    // Shift din through SYNC_STAGES flops; everything clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[SYNC_STAGES-2:0], din};
    end

    assign s = sr[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a bouncy input and only lets d follow it after STABLE
// consecutive agreeing samples; emits one-cycle rise/fall pulses on each change.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE      = DEF_STABLE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic d,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    generate
        if (!cfg_ok(SYNC_STAGES, STABLE, CNT_W)) begin : g_bad_cfg
            $error("debounce_sync: illegal SYNC_STAGES/STABLE/CNT_W combination");
        end
    endgenerate

    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .din (din),
        .s   (s)
    );

    // Qualification FSM: state, counter and all outputs are registered here.
    // Pulses default low every edge, so they last exactly one cycle and
    // are suppressed while en=0; everything else simply holds when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE_LO;
            cnt   <= '0;
            d     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                case (state)
                    IDLE_LO: begin
                        if (s) begin
                            if (STABLE == 1) begin
                                d     <= 1'b1;
                                rise  <= 1'b1;
                                state <= IDLE_HI;
                            end else begin
                                cnt   <= ONE;
                                busy  <= 1'b1;
                                state <= CHK_HI;
                            end
                        end
                    end
                    CHK_HI: begin
                        if (!s) begin
                            // glitch shorter than STABLE: drop it silently
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE_LO;
                        end else if (cnt == LAST) begin
                            d     <= 1'b1;
                            rise  <= 1'b1;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE_HI;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    IDLE_HI: begin
                        if (!s) begin
                            if (STABLE == 1) begin
                                d     <= 1'b0;
                                fall  <= 1'b1;
                                state <= IDLE_LO;
                            end else begin
                                cnt   <= ONE;
                                busy  <= 1'b1;
                                state <= CHK_LO;
                            end
                        end
                    end
                    CHK_LO: begin
                        if (s) begin
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE_HI;
                        end else if (cnt == LAST) begin
                            d     <= 1'b0;
                            fall  <= 1'b1;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE_LO;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed scenarios plus randomized bouncy input,
// checked through a scoreboard fed by a run-length reference model.
module tb_debounce_sync;

    localparam int SS = 2;
    localparam int ST = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic en  = 1'b1;
    logic d, rise, fall, busy;
    logic q;

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(SS), .STABLE(ST), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .en   (en),
        .d    (d),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    // downstream negedge flop fed by d
    always @(negedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= d;
    end

    typedef struct packed {
        logic d;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the FSM sees din from SS edges ago; d flips once ST
    // consecutive enabled samples disagree with it, and any agreeing sample
    // throws the pending run away.
    bit   hist[SS];
    bit   m_d;
    bit   m_s, m_r, m_f;
    bit   run[$];
    exp_t m_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d = 1'b0;
            for (int i = 0; i < SS; i++) hist[i] = 1'b0;
            run.delete();
            sb.delete();
        end else begin
            m_s = hist[SS-1];
            m_r = 1'b0;
            m_f = 1'b0;
            for (int i = SS-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = din;
            if (en) begin
                if (m_s == m_d) begin
                    run.delete();
                end else begin
                    run.push_back(m_s);
                    if (run.size() == ST) begin
                        m_d = m_s;
                        m_r = m_s;
                        m_f = !m_s;
                        run.delete();
                    end
                end
            end
            m_e.d    = m_d;
            m_e.rise = m_r;
            m_e.fall = m_f;
            m_e.busy = (run.size() != 0);
            sb.push_back(m_e);
        end
    end

    // Monitor: every cycle the DUT presents a new output set; pop and compare.
    exp_t mon_e;
    logic prev_d = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst d", d, 1'b0);
            chk("rst busy", busy, 1'b0);
            chk("rst q", q, 1'b0);
            prev_d = 1'b0;
        end else if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb d", d, mon_e.d);
            chk("sb rise", rise, mon_e.rise);
            chk("sb fall", fall, mon_e.fall);
            chk("sb busy", busy, mon_e.busy);
            chk("sb q", q, prev_d);
            prev_d = mon_e.d;
        end
    end

    task automatic drive(input logic di, input logic e, input int n);
        repeat (n) begin
            @(negedge clk);
            din = di;
            en  = e;
        end
    endtask

    logic rv;
    int   rlen;

    initial begin
        // 1: reset, then quiet input
        rst = 1'b1; din = 1'b0; en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset d", d, 1'b0);
        chk("reset rise", rise, 1'b0);
        chk("reset fall", fall, 1'b0);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b1, 10);

        // 2: held rise, explicit latency
        @(negedge clk);
        din = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk("t2 d", d, k == 6);
            chk("t2 rise", rise, k == 6);
            chk("t2 busy", busy, (k >= 3) && (k < 6));
        end
        @(negedge clk);
        #1;
        chk("t2 q", q, 1'b1);
        drive(1'b1, 1'b1, 5);

        // 3: short pulse rejected
        drive(1'b0, 1'b1, 12);
        drive(1'b1, 1'b1, 3);
        drive(1'b0, 1'b1, 10);
        chk("t3 d", d, 1'b0);

        // 4: bouncy fall from d=1
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 1);
        drive(1'b1, 1'b1, 1);
        drive(1'b0, 1'b1, 1);
        drive(1'b1, 1'b1, 1);
        drive(1'b0, 1'b1, 12);
        chk("t4 d", d, 1'b0);

        // 5: enable dropped mid-qualification
        drive(1'b1, 1'b1, 4);
        drive(1'b1, 1'b0, 5);
        chk("t5 held d", d, 1'b0);
        chk("t5 held busy", busy, 1'b1);
        drive(1'b1, 1'b1, 6);
        chk("t5 d", d, 1'b1);

        // 6a: async reset during CHK_LO with d=1
        drive(1'b0, 1'b1, 4);
        @(posedge clk);
        #1;
        chk("t6a pre busy", busy, 1'b1);
        chk("t6a pre d", d, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("t6a d", d, 1'b0);
        chk("t6a busy", busy, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;

        // 6b: async reset during CHK_HI
        drive(1'b0, 1'b1, 5);
        drive(1'b1, 1'b1, 4);
        @(posedge clk);
        #1;
        chk("t6b pre busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("t6b d", d, 1'b0);
        chk("t6b busy", busy, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;

        // random bouncy runs with sporadic enable drops
        for (int i = 0; i < 400; i++) begin
            rv   = 1'($urandom % 2);
            rlen = $urandom_range(1, 8);
            repeat (rlen) begin
                @(negedge clk);
                din = rv;
                en  = (($urandom % 8) != 0);
            end
        end
        drive(1'b0, 1'b1, 12);

        repeat (2) @(negedge clk);
        #1;
        chk("sb drained", sb.size() <= 1, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
